// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative MIPS multiply/divide unit:
// R-type funct codes, FSM state encoding and funct decode helpers.
package mul_div_unit_pkg;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // True for the four funct codes that start an iterative operation
  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_DIV);
  endfunction

  function automatic logic is_div_op(input logic [5:0] f);
    return (f == FN_DIV) || (f == FN_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Radix-2 iterative MIPS multiply/divide unit owning HI/LO.
// Magnitudes are iterated unsigned; signs are applied in the FIX state.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_stall
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned P_W   = 2 * WIDTH;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic               busy_d, done_d, div_zero_d;
  logic [WIDTH-1:0]   hi_d, lo_d;

  logic               accept;
  logic               op_dv;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_a, add_s;
  logic [P_W-1:0]     prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand decode and magnitude extraction at issue
  always_comb begin
    op_dv  = is_div_op(func);
    accept = start & ~busy & ~flush & is_muldiv(func);
    a_neg  = is_signed_op(func) & op_a[WIDTH-1];
    b_neg  = is_signed_op(func) & op_b[WIDTH-1];
    a_mag  = a_neg ? (~op_a + WIDTH'(1)) : op_a;
    b_mag  = b_neg ? (~op_b + WIDTH'(1)) : op_b;
  end

  // Shared adder: subtract for restoring divide, add for shift-add multiply
  always_comb begin
    add_a = is_div_q ? {acc_q, q_q[WIDTH-1]} : {1'b0, acc_q};
    add_s = is_div_q ? (add_a - {1'b0, b_q}) : (add_a + {1'b0, b_q});
  end

  // Sign correction of the finished magnitudes
  always_comb begin
    prod     = {acc_q, q_q};
    prod_fix = neg_res_q ? (~prod + P_W'(1)) : prod;
    quo_fix  = neg_res_q ? (~q_q + WIDTH'(1)) : q_q;
    rem_fix  = neg_rem_q ? (~acc_q + WIDTH'(1)) : acc_q;
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    q_d        = q_q;
    b_d        = b_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    busy_d     = busy;
    done_d     = 1'b0;
    div_zero_d = div_zero;
    hi_d       = hi;
    lo_d       = lo;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          is_div_d   = op_dv;
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          cnt_d      = CNT_W'(WIDTH);
          busy_d     = 1'b1;
          div_zero_d = op_dv & (op_b == '0);
          if (op_dv && (op_b == '0)) begin
            // Divide by zero skips iteration; raw dividend is kept for HI
            dz_d    = 1'b1;
            acc_d   = op_a;
            q_d     = '0;
            b_d     = '0;
            state_d = ST_FIX;
          end else begin
            dz_d    = 1'b0;
            acc_d   = '0;
            q_d     = op_dv ? a_mag : b_mag;
            b_d     = op_dv ? b_mag : a_mag;
            state_d = ST_RUN;
          end
        end else if (start && !flush && func == FN_MTHI) begin
          hi_d = op_a;
        end else if (start && !flush && func == FN_MTLO) begin
          lo_d = op_a;
        end
      end

      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          if (is_div_q) begin
            if (!add_s[WIDTH]) begin
              acc_d = add_s[WIDTH-1:0];
              q_d   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = add_a[WIDTH-1:0];
              q_d   = {q_q[WIDTH-2:0], 1'b0};
            end
          end else if (q_q[0]) begin
            acc_d = add_s[WIDTH:1];
            q_d   = {add_s[0], q_q[WIDTH-1:1]};
          end else begin
            acc_d = {1'b0, acc_q[WIDTH-1:1]};
            q_d   = {acc_q[0], q_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (!flush) begin
          done_d = 1'b1;
          if (dz_q) begin
            hi_d = acc_q;
            lo_d = '1;
          end else if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[P_W-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      b_q       <= b_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      busy      <= busy_d;
      done      <= done_d;
      div_zero  <= div_zero_d;
      hi        <= hi_d;
      lo        <= lo_d;
    end
  end

  // Register-file read port for MFHI/MFLO
  assign rd_data  = (func == FN_MFHI) ? hi : lo;
  assign rd_stall = start & ((func == FN_MFHI) | (func == FN_MFLO)) & busy;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit at WIDTH=32.
module tb_mul_div_unit;

  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTLO  = 6'b010011;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  func;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        busy, done, div_zero, rd_stall;
  logic [31:0] hi, lo, rd_data;

  int checks = 0;
  int errors = 0;
  int lat, bcyc, done_seen;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func(func),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo), .rd_data(rd_data), .rd_stall(rd_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, then count cycles from the accept edge until done (bounded)
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int latency, output int busy_cycles);
    @(negedge clk);
    start = 1'b1; func = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    latency = 0;
    busy_cycles = 0;
    forever begin
      if (busy) busy_cycles++;
      if (done || latency >= 100) break;
      @(posedge clk); #1;
      latency++;
    end
    check("done_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic drive_start(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; func = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; func = 6'd0; op_a = '0; op_b = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dz", {63'd0, div_zero}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Multiply, including latency and busy length
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcyc);
    check("multu_ff", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    check("multu_lat", 64'(lat), 64'd33);
    check("multu_busy", 64'(bcyc), 64'd33);
    check("busy_after_done", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    check("done_pulse", {63'd0, done}, 64'd0);

    run_op(MULT, 32'hFFFF_FFFD, 32'd7, lat, bcyc);
    check("mult_m3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(MULT, 32'h8000_0000, 32'h8000_0000, lat, bcyc);
    check("mult_min2", {hi, lo}, 64'h4000_0000_0000_0000);

    // Divide: signed truncation, unsigned, MIN/-1, negative divisor
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, lat, bcyc);
    check("div_m7d2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(DIVU, 32'd7, 32'd2, lat, bcyc);
    check("divu_7d2", {hi, lo}, 64'h0000_0001_0000_0003);
    check("divu_lat", 64'(lat), 64'd33);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcyc);
    check("div_min_m1", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(DIV, 32'd7, 32'hFFFF_FFFE, lat, bcyc);
    check("div_7dm2", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

    // Divide by zero: short path, sticky flag cleared by next accept
    run_op(DIVU, 32'h55, 32'd0, lat, bcyc);
    check("dz_flag", {63'd0, div_zero}, 64'd1);
    check("dz_hilo", {hi, lo}, 64'h0000_0055_FFFF_FFFF);
    check("dz_lat", 64'(lat), 64'd1);
    drive_start(MULTU, 32'd3, 32'd5);
    check("dz_clear", {63'd0, div_zero}, 64'd0);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("multu_3x5", {hi, lo}, 64'h0000_0000_0000_000F);

    // Start while busy dropped; flush mid-run cancels without done
    drive_start(MULTU, 32'd2, 32'd3);
    repeat (4) @(posedge clk);
    drive_start(MULT, 32'd9, 32'd9);
    check("drop_busy", {63'd0, busy}, 64'd1);
    repeat (4) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_done", {63'd0, done}, 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("flush_no_done", 64'(done_seen), 64'd0);
    check("flush_hilo", {hi, lo}, 64'h0000_0000_0000_000F);
    run_op(MULTU, 32'd4, 32'd5, lat, bcyc);
    check("post_flush_mul", {hi, lo}, 64'h0000_0000_0000_0014);

    // Moves, reads and stall
    drive_start(MTHI, 32'h1234, 32'd0);
    check("mthi", 64'(hi), 64'h1234);
    @(negedge clk);
    start = 1'b1; func = MFHI;
    #1;
    check("mfhi_data", 64'(rd_data), 64'h1234);
    check("mfhi_nostall", {63'd0, rd_stall}, 64'd0);
    @(negedge clk) start = 1'b0;
    drive_start(DIV, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b1; func = MFLO;
    #1;
    check("mflo_stall", {63'd0, rd_stall}, 64'd1);
    @(negedge clk);
    func = MTLO; op_a = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_ignored", 64'(lo), 64'h14);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
